// File: rtl/cpu_clk_pkg.sv
// Shared types and helpers for the 580-family clock-enable generator.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    SPD_1X  = 2'd0,
    SPD_2X  = 2'd1,
    SPD_3X  = 2'd2,
    SPD_RSV = 2'd3
  } speed_t;

  // CPU sub-period length for a given speed; the reserved code runs at 1x.
  function automatic int unsigned sub_period(input speed_t spd, input int unsigned base_div);
    int unsigned n;
    unique case (spd)
      SPD_2X:  n = 2;
      SPD_3X:  n = 3;
      default: n = 1;
    endcase
    return base_div / n;
  endfunction

endpackage

// File: rtl/clk_ce_gen_reset_stretch.sv
// Stretches a level reset request into a CPU reset held RST_LEN cycles past release.
module reset_stretch #(
  parameter int unsigned RST_LEN = 15
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic reset_req,
  output logic cpu_reset
);

  localparam int unsigned CNTW = $clog2(RST_LEN + 1);
  localparam logic [CNTW-1:0] CNT_END = CNTW'(RST_LEN);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            cpu_reset_q, cpu_reset_d;

  // Counter clears while requested, then saturates at RST_LEN; reset drops on reaching it.
  always_comb begin
    cnt_d       = cnt_q;
    cpu_reset_d = 1'b1;
    if (reset_req) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_END) begin
      cnt_d = cnt_q + CNTW'(1);
    end
    cpu_reset_d = reset_req || (cnt_q != CNT_END);
  end

  // State and registered reset output.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      cpu_reset_q <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  assign cpu_reset = cpu_reset_q;

endmodule

// File: rtl/clk_ce_gen.sv
// Clock-enable and reset generator: CPU two-phase, PIT and pixel enables from clk_sys.
module clk_ce_gen
  import cpu_clk_pkg::*;
#(
  parameter int unsigned CPU_DIV  = 54,
  parameter int unsigned PHI2_OFS = 13,
  parameter int unsigned PIT_OFS  = 8,
  parameter int unsigned PIX_DIV  = 12,
  parameter int unsigned RST_LEN  = 15
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [1:0] speed,
  input  logic       pause,
  input  logic       reset_req,
  output logic       ce_f1,
  output logic       ce_f2,
  output logic       ce_pit,
  output logic       ce_pix,
  output logic       cpu_reset,
  output logic       period_end
);

  localparam int unsigned CW = $clog2(CPU_DIV);
  localparam int unsigned PW = $clog2(PIX_DIV);

  localparam logic [CW-1:0] DIV_LAST  = CW'(CPU_DIV - 1);
  localparam logic [CW-1:0] PHI2_POS  = CW'(PHI2_OFS);
  localparam logic [CW-1:0] PIT_POS   = CW'(PIT_OFS);
  localparam logic [CW-1:0] SUB1_LAST = CW'(sub_period(SPD_1X, CPU_DIV) - 1);
  localparam logic [CW-1:0] SUB2_LAST = CW'(sub_period(SPD_2X, CPU_DIV) - 1);
  localparam logic [CW-1:0] SUB3_LAST = CW'(sub_period(SPD_3X, CPU_DIV) - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(PIX_DIV - 1);

  logic [CW-1:0] cpu_div_q, cpu_div_d;
  logic [CW-1:0] sub_q, sub_d;
  logic [PW-1:0] pix_q, pix_d;
  speed_t        mult_q, mult_d;
  logic          pause_q, pause_d;
  logic          ce_f1_q, ce_f1_d;
  logic          ce_f2_q, ce_f2_d;
  logic          ce_pit_q, ce_pit_d;
  logic          ce_pix_q, ce_pix_d;
  logic          period_end_q, period_end_d;
  logic [CW-1:0] sub_last;
  logic          period_last;

  // Dividers, period-boundary sampling of speed/pause, and enable decode of current state.
  // The sub-counter realigns at every base wrap, so a speed change never shortens spacing.
  always_comb begin
    unique case (mult_q)
      SPD_2X:  sub_last = SUB2_LAST;
      SPD_3X:  sub_last = SUB3_LAST;
      default: sub_last = SUB1_LAST;
    endcase

    period_last = (cpu_div_q == DIV_LAST);
    cpu_div_d   = period_last ? '0 : cpu_div_q + CW'(1);
    sub_d       = (period_last || sub_q == sub_last) ? '0 : sub_q + CW'(1);
    pix_d       = (pix_q == PIX_LAST) ? '0 : pix_q + PW'(1);

    mult_d  = mult_q;
    pause_d = pause_q;
    if (period_last) begin
      mult_d  = (speed_t'(speed) == SPD_RSV) ? SPD_1X : speed_t'(speed);
      pause_d = pause;
    end

    ce_f1_d      = !pause_q && (sub_q == '0);
    ce_f2_d      = !pause_q && (sub_q == PHI2_POS);
    ce_pit_d     = !pause_q && (cpu_div_q == PIT_POS);
    ce_pix_d     = (pix_q == '0);
    period_end_d = period_last;
  end

  // Counter, latched-mode and output registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cpu_div_q    <= '0;
      sub_q        <= '0;
      pix_q        <= '0;
      mult_q       <= SPD_1X;
      pause_q      <= 1'b0;
      ce_f1_q      <= 1'b0;
      ce_f2_q      <= 1'b0;
      ce_pit_q     <= 1'b0;
      ce_pix_q     <= 1'b0;
      period_end_q <= 1'b0;
    end else begin
      cpu_div_q    <= cpu_div_d;
      sub_q        <= sub_d;
      pix_q        <= pix_d;
      mult_q       <= mult_d;
      pause_q      <= pause_d;
      ce_f1_q      <= ce_f1_d;
      ce_f2_q      <= ce_f2_d;
      ce_pit_q     <= ce_pit_d;
      ce_pix_q     <= ce_pix_d;
      period_end_q <= period_end_d;
    end
  end

  reset_stretch #(
    .RST_LEN(RST_LEN)
  ) u_reset_stretch (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .reset_req (reset_req),
    .cpu_reset (cpu_reset)
  );

  assign ce_f1      = ce_f1_q;
  assign ce_f2      = ce_f2_q;
  assign ce_pit     = ce_pit_q;
  assign ce_pix     = ce_pix_q;
  assign period_end = period_end_q;

endmodule
